serial_alu_seq: RTL

Bit-serial ALU controller. It sequences a single 1-bit ALU slice over WIDTH clock cycles, LSB first, to execute full-width AND/OR/ADD/SUB/SLT. The block owns the operand shift registers, the carry flop, the slice control lines and a start/done handshake. It sits beside the register file as a low-area alternative to the parallel ALU.

---
 rtl/serial_alu_pkg.sv | 30 +++
 rtl/serial_alu_bit.sv | 36 +++
 rtl/serial_alu_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, FSM states and
// the 1-bit slice function select.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SL_AND  = 2'b00;
    localparam logic [1:0] SL_OR   = 2'b01;
    localparam logic [1:0] SL_ADD  = 2'b10;
    localparam logic [1:0] SL_LESS = 2'b11;

    // Undefined codes collapse to AND so the slice never sees a stray select.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: norm_op = op;
            default:                               norm_op = OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational 1-bit ALU slice: and/or/add/less with operand inversion,
// exposing carry out and the raw sum as 'set'.
module serial_alu_bit
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       set
);

    logic aa, bb, sum;

    assign aa   = a ^ ainvert;
    assign bb   = b ^ binvert;
    assign sum  = aa ^ bb ^ cin;
    assign cout = (aa & bb) | (aa & cin) | (bb & cin);
    assign set  = sum;

    always_comb begin
        result = 1'b0;
        case (op)
            SL_AND:  result = aa & bb;
            SL_OR:   result = aa | bb;
            SL_ADD:  result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: runs one serial_alu_bit over WIDTH cycles, LSB first.
// Optional SERIAL_ALU_OVF_EN adds the ovf port and a signed-correct SLT.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef SERIAL_ALU_OVF_EN
    , output logic           ovf
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
    logic [2:0]       op_q, op_d, op_n;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d, set_q, set_d, cout_q, cout_d, zero_q, zero_d;
    logic             s_res, s_cout, s_set, last, is_arith, slt_bit;
    logic [WIDTH-1:0] fin;
`ifdef SERIAL_ALU_OVF_EN
    logic             ovf_q, ovf_d, ovf_now;
`endif

    assign op_n     = norm_op(op);
    assign last     = (cnt_q == CNTW'(WIDTH - 1));
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    serial_alu_bit u_bit (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .ainvert (1'b0),
        .binvert (op_q[2]),
        .cin     (carry_q),
        .less    (1'b0),
        .op      (op_q[1:0]),
        .result  (s_res),
        .cout    (s_cout),
        .set     (s_set)
    );

`ifdef SERIAL_ALU_OVF_EN
    // Carry into the MSB slice is the carry flop while bit WIDTH-1 is processed.
    assign ovf_now = carry_q ^ s_cout;
    assign slt_bit = s_set ^ ovf_now;
`else
    assign slt_bit = s_set;
`endif

    assign fin = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, set_q} : sh_q;

    // The DONE cycle presents the freshly assembled result; the held copy
    // covers IDLE and RUN so no partial shift-register value leaks out.
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = done ? fin : result_q;
    assign zero   = done ? (fin == '0) : zero_q;
    assign cout   = cout_q;
`ifdef SERIAL_ALU_OVF_EN
    assign ovf    = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        set_d    = set_q;
        cout_d   = cout_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_n;
                    cnt_d   = '0;
                    carry_d = op_n[2];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = s_cout;
                sh_d    = {s_res, sh_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (last) begin
                    set_d   = slt_bit;
                    cout_d  = is_arith ? s_cout : 1'b0;
`ifdef SERIAL_ALU_OVF_EN
                    ovf_d   = is_arith ? ovf_now : 1'b0;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_DONE: begin
                result_d = fin;
                zero_d   = (fin == '0);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            set_q    <= 1'b0;
            cout_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            set_q    <= set_d;
            cout_q   <= cout_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule
